// File: rtl/debug_dump_engine.sv
// Byte-serialises halted-processor debug state (PC, register bank, data memory) to the debug UART.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module debug_dump_engine #(
  parameter int WORD_W     = 32,
  parameter int RB_DEPTH   = 32,
  parameter int RB_ADDR_W  = 5,
  parameter int MEM_DEPTH  = 32,
  parameter int MEM_ADDR_W = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [WORD_W-1:0]     i_pc_value,
  input  logic [WORD_W-1:0]     i_rb_data,
  input  logic [WORD_W-1:0]     i_mem_data,
  input  logic                  i_tx_done,
  output logic [RB_ADDR_W-1:0]  o_rb_addr,
  output logic                  o_rb_read_enable,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic                  o_mem_read_enable,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_state
);

  localparam int NB    = WORD_W / 8;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int IDX_W = (RB_ADDR_W > MEM_ADDR_W) ? RB_ADDR_W : MEM_ADDR_W;
  localparam bit HAS_MEM = (MEM_DEPTH > 0);
  localparam logic [BC_W-1:0]  BYTE_LAST = BC_W'(NB - 1);
  localparam logic [IDX_W-1:0] RB_LAST   = IDX_W'(RB_DEPTH - 1);
  localparam logic [IDX_W-1:0] MEM_LAST  = IDX_W'((MEM_DEPTH > 0) ? MEM_DEPTH - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    NEXT    = 3'd5,
`ifdef DUMP_CHECKSUM_EN
    CHK     = 3'd6,
`endif
    DONE    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC  = 2'd0,
    SEC_REG = 2'd1,
    SEC_MEM = 2'd2
  } section_t;

  state_t            state;
  state_t            state_next;
  section_t          section;
  logic [WORD_W-1:0] shift_reg;
  logic [BC_W-1:0]   byte_cnt;
  logic [IDX_W-1:0]  word_idx;
  logic              last_word;
  logic              last_byte;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] checksum;
  logic       chk_sent;
`endif

  assign last_byte = (byte_cnt == BYTE_LAST);
  // The dump ends at the last memory word, or at the last register when there is no memory section.
  assign last_word = ((section == SEC_MEM) && (word_idx == MEM_LAST)) ||
                     ((section == SEC_REG) && (word_idx == RB_LAST) && !HAS_MEM);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = SEND;
      FETCH:   state_next = LATCH;
      LATCH:   state_next = SEND;
      SEND:    state_next = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_next = NEXT;
      NEXT: begin
        if (!last_byte) begin
          state_next = SEND;
        end else if (last_word) begin
`ifdef DUMP_CHECKSUM_EN
          state_next = CHK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = FETCH;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CHK:     if (chk_sent && i_tx_done) state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
      word_idx  <= '0;
      section   <= SEC_PC;
`ifdef DUMP_CHECKSUM_EN
      checksum  <= '0;
      chk_sent  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            shift_reg <= i_pc_value;
            section   <= SEC_PC;
            byte_cnt  <= '0;
            word_idx  <= '0;
`ifdef DUMP_CHECKSUM_EN
            checksum  <= '0;
            chk_sent  <= 1'b0;
`endif
          end
        end
        LATCH: begin
          shift_reg <= (section == SEC_MEM) ? i_mem_data : i_rb_data;
          byte_cnt  <= '0;
        end
`ifdef DUMP_CHECKSUM_EN
        SEND: checksum <= checksum ^ shift_reg[7:0];
        CHK:  chk_sent <= 1'b1;
`endif
        NEXT: begin
          if (!last_byte) begin
            shift_reg <= shift_reg >> 8;
            byte_cnt  <= byte_cnt + 1'b1;
          end else begin
            // Word advance saturates at each section's last index rather than wrapping the address.
            case (section)
              SEC_PC: begin
                section  <= SEC_REG;
                word_idx <= '0;
              end
              SEC_REG: begin
                if (word_idx != RB_LAST) begin
                  word_idx <= word_idx + 1'b1;
                end else if (HAS_MEM) begin
                  section  <= SEC_MEM;
                  word_idx <= '0;
                end
              end
              SEC_MEM: begin
                if (word_idx != MEM_LAST) word_idx <= word_idx + 1'b1;
              end
              default: section <= SEC_PC;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_rb_read_enable  = 1'b0;
    o_mem_read_enable = 1'b0;
    o_rb_addr         = '0;
    o_mem_addr        = '0;
    o_tx_start        = 1'b0;
    o_tx_data         = 8'h00;
    if ((state == FETCH) || (state == LATCH)) begin
      if (section == SEC_REG) begin
        o_rb_addr        = word_idx[RB_ADDR_W-1:0];
        o_rb_read_enable = (state == FETCH);
      end else if (section == SEC_MEM) begin
        o_mem_addr        = word_idx[MEM_ADDR_W-1:0];
        o_mem_read_enable = (state == FETCH);
      end
    end
    if (state == SEND) begin
      o_tx_start = 1'b1;
      o_tx_data  = shift_reg[7:0];
    end else if (state == WAIT_TX) begin
      o_tx_data  = shift_reg[7:0];
    end
`ifdef DUMP_CHECKSUM_EN
    if (state == CHK) begin
      o_tx_data  = checksum;
      o_tx_start = !chk_sent;
    end
`endif
  end

  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_state = state;

endmodule

// File: tb/tb_debug_dump_engine.sv
// Directed bench for debug_dump_engine: a 4-reg/2-mem instance and a 4-reg/no-mem instance,
// each with a register-file model, memory model and a UART model acking 10 cycles after tx_start.
module tb_debug_dump_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] pc_value;

  logic        start_a, tx_done_a, ack_a, spur_a, spur_en_a;
  logic [31:0] rb_data_a, mem_data_a;
  logic [4:0]  rb_addr_a, mem_addr_a;
  logic        rb_en_a, mem_en_a, tx_start_a, busy_a, done_a;
  logic [7:0]  tx_data_a;
  logic [2:0]  state_a;
  int          ack_cnt_a;

  logic        start_b, tx_done_b, ack_b;
  logic [31:0] rb_data_b, mem_data_b;
  logic [4:0]  rb_addr_b, mem_addr_b;
  logic        rb_en_b, mem_en_b, tx_start_b, busy_b, done_b;
  logic [7:0]  tx_data_b;
  logic [2:0]  state_b;
  int          ack_cnt_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] bytes_a[$];
  logic [7:0] bytes_b[$];
  logic [7:0] exp_q[$];
  int rb_cnt_a, mem_cnt_a, both_a, done_cnt_a;
  int rb_cnt_b, mem_cnt_b, done_cnt_b;

  debug_dump_engine #(.WORD_W(32), .RB_DEPTH(4), .RB_ADDR_W(5), .MEM_DEPTH(2), .MEM_ADDR_W(5)) dut (
    .i_clock(clock), .i_reset(reset), .i_start(start_a), .i_pc_value(pc_value),
    .i_rb_data(rb_data_a), .i_mem_data(mem_data_a), .i_tx_done(tx_done_a),
    .o_rb_addr(rb_addr_a), .o_rb_read_enable(rb_en_a), .o_mem_addr(mem_addr_a),
    .o_mem_read_enable(mem_en_a), .o_tx_data(tx_data_a), .o_tx_start(tx_start_a),
    .o_busy(busy_a), .o_done(done_a), .o_state(state_a)
  );

  debug_dump_engine #(.WORD_W(32), .RB_DEPTH(4), .RB_ADDR_W(5), .MEM_DEPTH(0), .MEM_ADDR_W(5)) dut_nomem (
    .i_clock(clock), .i_reset(reset), .i_start(start_b), .i_pc_value(pc_value),
    .i_rb_data(rb_data_b), .i_mem_data(mem_data_b), .i_tx_done(tx_done_b),
    .o_rb_addr(rb_addr_b), .o_rb_read_enable(rb_en_b), .o_mem_addr(mem_addr_b),
    .o_mem_read_enable(mem_en_b), .o_tx_data(tx_data_b), .o_tx_start(tx_start_b),
    .o_busy(busy_b), .o_done(done_b), .o_state(state_b)
  );

  // Read-port models: data appears one cycle after the strobe.
  always @(posedge clock) begin
    if (rb_en_a)  rb_data_a  <= 32'hA0 + 32'(rb_addr_a);
    if (mem_en_a) mem_data_a <= 32'hB0 + 32'(mem_addr_a);
    if (rb_en_b)  rb_data_b  <= 32'hA0 + 32'(rb_addr_b);
    if (mem_en_b) mem_data_b <= 32'hB0 + 32'(mem_addr_b);
  end

  // UART models.
  always @(posedge clock) begin
    if (reset) begin
      ack_cnt_a <= 0; ack_a <= 1'b0;
      ack_cnt_b <= 0; ack_b <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      if (tx_start_a) ack_cnt_a <= 10;
      else if (ack_cnt_a != 0) begin
        ack_cnt_a <= ack_cnt_a - 1;
        if (ack_cnt_a == 1) ack_a <= 1'b1;
      end
      if (tx_start_b) ack_cnt_b <= 10;
      else if (ack_cnt_b != 0) begin
        ack_cnt_b <= ack_cnt_b - 1;
        if (ack_cnt_b == 1) ack_b <= 1'b1;
      end
    end
  end

  assign tx_done_a = ack_a | spur_a;
  assign tx_done_b = ack_b;

  // Spurious tx_done only in IDLE/FETCH/LATCH.
  always @(negedge clock) begin
    spur_a = spur_en_a && ((state_a == 3'd0) || (state_a == 3'd1) || (state_a == 3'd2));
  end

  always @(negedge clock) begin
    if (tx_start_a) bytes_a.push_back(tx_data_a);
    if (rb_en_a)    rb_cnt_a++;
    if (mem_en_a)   mem_cnt_a++;
    if (rb_en_a && mem_en_a) both_a++;
    if (done_a)     done_cnt_a++;
    if (tx_start_b) bytes_b.push_back(tx_data_b);
    if (rb_en_b)    rb_cnt_b++;
    if (mem_en_b)   mem_cnt_b++;
    if (done_b)     done_cnt_b++;
  end

  task automatic build_expected(input int mem_depth);
    logic [7:0] x;
    exp_q.delete();
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(pc_value >> (8 * b)));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'hA0 + i)); exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);         exp_q.push_back(8'h00);
    end
    for (int i = 0; i < mem_depth; i++) begin
      exp_q.push_back(8'(8'hB0 + i)); exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);         exp_q.push_back(8'h00);
    end
`ifdef DUMP_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`endif
  endtask

  task automatic clear_a();
    bytes_a.delete();
    rb_cnt_a = 0; mem_cnt_a = 0; both_a = 0; done_cnt_a = 0;
  endtask

  task automatic wait_done_a(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start_a();
    @(negedge clock);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (state_a !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %0d expected 0", state_a);
    end
    tests_run++;
    if ({busy_a, done_a, tx_start_a} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got busy/done/start=%b expected 000", {busy_a, done_a, tx_start_a});
    end
    tests_run++;
    if ({tx_data_a, rb_en_a, mem_en_a, rb_addr_a, mem_addr_a} !== 20'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got data=%h rb_en=%b mem_en=%b rb_addr=%0d mem_addr=%0d expected all 0",
               tx_data_a, rb_en_a, mem_en_a, rb_addr_a, mem_addr_a);
    end
  endtask

  task automatic test_full_dump();
    bit seen;
    build_expected(2);
    clear_a();
    @(negedge clock);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    tests_run++;
    if (tx_start_a !== 1'b1 || tx_data_a !== 8'h44) begin
      tests_failed++;
      $display("[TB] FAIL first_byte_latency: got start=%b data=%h expected start=1 data=44", tx_start_a, tx_data_a);
    end
    wait_done_a(seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL full_dump_timeout: got no o_done expected o_done within 3000 cycles");
    end
    repeat (3) @(negedge clock);
    tests_run++;
    if (bytes_a.size() !== exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL full_dump_len: got %0d expected %0d", bytes_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < bytes_a.size(); i++) begin
      tests_run++;
      if (bytes_a[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL full_dump_byte%0d: got %h expected %h", i, bytes_a[i], exp_q[i]);
      end
    end
    tests_run++;
    if (done_cnt_a !== 1) begin
      tests_failed++;
      $display("[TB] FAIL full_dump_done_count: got %0d expected 1", done_cnt_a);
    end
    tests_run++;
    if (rb_cnt_a !== 4 || mem_cnt_a !== 2 || both_a !== 0) begin
      tests_failed++;
      $display("[TB] FAIL read_strobes: got rb=%0d mem=%0d both=%0d expected 4 2 0", rb_cnt_a, mem_cnt_a, both_a);
    end
    tests_run++;
    if (busy_a !== 1'b0 || state_a !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL full_dump_idle: got busy=%b state=%0d expected 0 0", busy_a, state_a);
    end
  endtask

  task automatic test_ignored_start();
    bit seen;
    int busy_seen;
    build_expected(2);
    clear_a();
    pulse_start_a();
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (done_a) begin
        seen = 1'b1;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        break;
      end
      start_a = ((c % 37) == 5);
    end
    start_a = 1'b0;
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL ignored_start_timeout: got no o_done expected o_done within 3000 cycles");
    end
    busy_seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (busy_a) busy_seen++;
    end
    tests_run++;
    if (busy_seen !== 0 || done_cnt_a !== 1) begin
      tests_failed++;
      $display("[TB] FAIL ignored_start_rerun: got busy_cycles=%0d done=%0d expected 0 1", busy_seen, done_cnt_a);
    end
    tests_run++;
    if (bytes_a.size() !== exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL ignored_start_len: got %0d expected %0d", bytes_a.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_dump();
    bit seen;
    int starts;
    build_expected(2);
    clear_a();
    pulse_start_a();
    starts = 0;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (tx_start_a) starts++;
      if (starts == 6) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_timeout: got %0d tx_starts expected 6", starts);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests_run++;
    if (state_a !== 3'd0 || busy_a !== 1'b0 || tx_start_a !== 1'b0 || tx_data_a !== 8'h00 ||
        rb_en_a !== 1'b0 || mem_en_a !== 1'b0 || done_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_idle: got state=%0d busy=%b start=%b data=%h expected 0 0 0 00",
               state_a, busy_a, tx_start_a, tx_data_a);
    end
    repeat (2) @(negedge clock);
    clear_a();
    pulse_start_a();
    wait_done_a(seen);
    repeat (3) @(negedge clock);
    tests_run++;
    if (!seen || bytes_a.size() !== exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL restart_len: got done=%b len=%0d expected 1 %0d", seen, bytes_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < bytes_a.size(); i++) begin
      tests_run++;
      if (bytes_a[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL restart_byte%0d: got %h expected %h", i, bytes_a[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_spurious_tx_done();
    bit seen;
    int moved;
    build_expected(2);
    spur_en_a = 1'b1;
    moved = 0;
    repeat (10) begin
      @(negedge clock);
      if (state_a !== 3'd0) moved++;
    end
    tests_run++;
    if (moved !== 0) begin
      tests_failed++;
      $display("[TB] FAIL spurious_idle: got %0d non-idle cycles expected 0", moved);
    end
    clear_a();
    pulse_start_a();
    wait_done_a(seen);
    repeat (3) @(negedge clock);
    spur_en_a = 1'b0;
    tests_run++;
    if (!seen || bytes_a.size() !== exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL spurious_len: got done=%b len=%0d expected 1 %0d", seen, bytes_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < bytes_a.size(); i++) begin
      tests_run++;
      if (bytes_a[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL spurious_byte%0d: got %h expected %h", i, bytes_a[i], exp_q[i]);
      end
    end
    tests_run++;
    if (rb_cnt_a !== 4) begin
      tests_failed++;
      $display("[TB] FAIL spurious_rb_strobes: got %0d expected 4", rb_cnt_a);
    end
  endtask

  task automatic test_no_mem_section();
    bit seen;
    build_expected(0);
    bytes_b.delete();
    rb_cnt_b = 0; mem_cnt_b = 0; done_cnt_b = 0;
    @(negedge clock);
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (done_b) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clock);
    tests_run++;
    if (!seen || bytes_b.size() !== exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL nomem_len: got done=%b len=%0d expected 1 %0d", seen, bytes_b.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < bytes_b.size(); i++) begin
      tests_run++;
      if (bytes_b[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL nomem_byte%0d: got %h expected %h", i, bytes_b[i], exp_q[i]);
      end
    end
    tests_run++;
    if (bytes_b.size() > 16 && bytes_b[16] !== 8'hA3) begin
      tests_failed++;
      $display("[TB] FAIL nomem_last_reg: got %h expected a3", bytes_b[16]);
    end
    tests_run++;
    if (mem_cnt_b !== 0 || rb_cnt_b !== 4 || done_cnt_b !== 1) begin
      tests_failed++;
      $display("[TB] FAIL nomem_strobes: got mem=%0d rb=%0d done=%0d expected 0 4 1", mem_cnt_b, rb_cnt_b, done_cnt_b);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    spur_en_a = 1'b0;
    spur_a    = 1'b0;
    pc_value  = 32'h11223344;
    clear_a();
    rb_cnt_b = 0; mem_cnt_b = 0; done_cnt_b = 0;
    test_reset();
    test_full_dump();
    test_ignored_start();
    test_reset_mid_dump();
    test_spurious_tx_done();
    test_no_mem_section();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
